pci_target_responder: RTL
=========================

// Module: pci_target_responder
// PURPOSE
//  Simplified PCI target: the responding end of the PCI bus whose rules our
//  protocol property checker enforces. Claims memory read/write cycles to a
//  small register window and drives DEVSEL_, TRDY_, STOP_ and the read data.
//  Sits on the shared bus model next to the master BFM and the property checker.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  byte base of window; aligned to DEPTH*4
//  DEPTH        16             32-bit registers in window (power of 2, >=2)
//  WAIT_STATES  1              cycles TRDY_ is held off in first data phase (0..7)
// PORTS
//  clk      in   1   bus clock, all logic on rising edge
//  reset    in   1   synchronous, active-high reset
//  FRAME_   in   1   master cycle framing, active low
//  IRDY_    in   1   master ready, active low
//  C_BE_    in   4   command (address phase) / byte enables (data phase), active low
//  AD_in    in   32  sampled AD bus
//  AD_out   out  32  read data driven onto AD
//  AD_oe    out  1   AD_out drive enable
//  DEVSEL_  out  1   device select, active low
//  TRDY_    out  1   target ready, active low
//  STOP_    out  1   target disconnect request, active low
// BEHAVIOUR
//  Reset: DEVSEL_=TRDY_=STOP_=1, AD_oe=0, AD_out=0, all registers=0, state IDLE.
//   Reset wins over any in-flight transaction; no turnaround cycle after it.
//  Address phase: edge where FRAME_=0 and FRAME_ was 1 on the previous edge.
//   Claim iff C_BE_ is 4'b0110 (mem read) or 4'b0111 (mem write) and
//   AD_in[31:log2(DEPTH)+2] == BASE_ADDR[31:log2(DEPTH)+2].
//   Word index = AD_in[log2(DEPTH)+1:2]. AD_in[1:0] ignored.
//   No claim -> stay IDLE, outputs untouched.
//  States: IDLE -> WAIT -> DATA -> TURN -> IDLE; DATA -> DISC -> TURN.
//  WAIT: entered on claim; DEVSEL_=0 from the next cycle.
//   Reads: AD_oe=1 and AD_out=reg[index] from the same cycle.
//   A counter loads WAIT_STATES; TRDY_ goes low once it reaches 0.
//   WAIT_STATES=0 -> TRDY_ low together with DEVSEL_.
//  DATA: a transfer completes on each edge with IRDY_=0 and TRDY_=0.
//   Write: reg[index] byte i <- AD_in byte i where C_BE_[i]=0.
//   Read: master takes AD_out; AD_out updates to the next index the cycle after.
//   Transfer with FRAME_=1 (last phase) -> TURN.
//   Transfer with FRAME_=0 -> index+1, TRDY_ held low; no wait states after
//    the first phase.
//   Transfer with FRAME_=0 at index=DEPTH-1 -> DISC (no wrap-around).
//   IRDY_=1 -> hold state and data; master wait states are unlimited.
//  DISC: STOP_=0, TRDY_=1, DEVSEL_=0, AD_oe unchanged. Stays in DISC until
//   FRAME_ is sampled 1, then TRDY_=1, STOP_=1 and -> TURN.
//  TURN: exactly one cycle with DEVSEL_=TRDY_=STOP_=1, AD_oe=0; then IDLE.
//   A new address phase on the TURN edge is ignored; IDLE samples the next.
//  DEVSEL_=1 always forces TRDY_=1. AD_out/C_BE_ never X while TRDY_=0 on a read.
//  FRAME_ rising while IRDY_=1 is a master protocol error; the target keeps
//   waiting for a transfer and does not recover on its own. The checker
//   flags this case.
// TESTING
//  1 Write 0x1000 cmd 0111, data 0xDEADBEEF, BE 0000, WAIT_STATES=1
//    -> DEVSEL_ low at cycle +1, TRDY_ low at +2; reg[0]=0xDEADBEEF.
//  2 Write 0x1004 data 0x11223344, BE 1010; reg[1] was 0xAAAAAAAA
//    -> reg[1]=0xAA22AA44.
//  3 Burst read 4 words from 0x1008, IRDY_ high on the 2nd phase
//    -> AD_out = reg[2..5] in order; reg[3] held during the master stall;
//       TURN cycle, then IDLE.
//  4 Burst write from 0x103C with FRAME_ low for 2 phases
//    -> reg[15] written, then STOP_ low and TRDY_ high; TURN after FRAME_ high.
//  5 Read from 0x2000, or cmd 0010 to 0x1000
//    -> DEVSEL_, TRDY_ and STOP_ stay 1; AD_oe stays 0.
//  6 reset asserted in the DATA state of a read
//    -> next edge: all outputs at reset values, regs 0; next cycle claimed
//       normally; run property checks 1-5 throughout.

Source files
------------

// File: rtl/pci_target_responder.sv
// pci_target_responder: simplified PCI memory target claiming a DEPTH-word register window.
// Latency: DEVSEL_ one cycle after the address phase, TRDY_ WAIT_STATES cycles after that; burst phases back to back.
// Backpressure: IRDY_ high holds state and data indefinitely; bursts running off the window end get STOP_.
module pci_target_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FRAME_,
  input  logic        IRDY_,
  input  logic [3:0]  C_BE_,
  input  logic [31:0] AD_in,
  output logic [31:0] AD_out,
  output logic        AD_oe,
  output logic        DEVSEL_,
  output logic        TRDY_,
  output logic        STOP_
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_DISC,
    S_TURN
  } state_t;

  state_t          state_q, state_d;
  logic            devsel_q, devsel_d;
  logic            trdy_q, trdy_d;
  logic            stop_q, stop_d;
  logic            ad_oe_q, ad_oe_d;
  logic [31:0]     ad_out_q, ad_out_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            is_rd_q, is_rd_d;
  logic            frame_q;
  logic            we;
  logic [31:0]     wr_dat;
  logic [31:0]     regs [DEPTH];

  // Address bits [1:0] carry no meaning for memory cycles here.
  logic unused_ad_low;
  assign unused_ad_low = ^AD_in[1:0];

  logic          addr_phase;
  logic          hit;
  logic          rd_cmd;
  logic          wr_cmd;
  logic [IW-1:0] ad_idx;
  logic [IW-1:0] idx_nxt;
  logic          xfer;

  assign addr_phase = !FRAME_ && frame_q;
  assign hit        = (AD_in[31:IW+2] == BASE_ADDR[31:IW+2]);
  assign rd_cmd     = (C_BE_ == 4'b0110);
  assign wr_cmd     = (C_BE_ == 4'b0111);
  assign ad_idx     = AD_in[IW+1:2];
  assign idx_nxt    = idx_q + IW'(1);
  assign xfer       = !IRDY_ && !trdy_q;

  assign AD_out  = ad_out_q;
  assign AD_oe   = ad_oe_q;
  assign DEVSEL_ = devsel_q;
  assign TRDY_   = trdy_q;
  assign STOP_   = stop_q;

  // Merge enabled write bytes over the current register contents.
  always_comb begin
    wr_dat = regs[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (!C_BE_[i]) wr_dat[8*i +: 8] = AD_in[8*i +: 8];
    end
  end

  // Next-state and next-output logic for the target sequencer.
  always_comb begin
    state_d  = state_q;
    devsel_d = devsel_q;
    trdy_d   = trdy_q;
    stop_d   = stop_q;
    ad_oe_d  = ad_oe_q;
    ad_out_d = ad_out_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    is_rd_d  = is_rd_q;
    we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (addr_phase && hit && (rd_cmd || wr_cmd)) begin
          is_rd_d  = rd_cmd;
          idx_d    = ad_idx;
          devsel_d = 1'b0;
          ad_oe_d  = rd_cmd;
          if (rd_cmd) ad_out_d = regs[ad_idx];
          if (WAIT_STATES == 0) begin
            trdy_d  = 1'b0;
            state_d = S_DATA;
          end else begin
            cnt_d   = 3'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          trdy_d  = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          we = !is_rd_q;
          if (FRAME_) begin
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
            stop_d   = 1'b1;
            ad_oe_d  = 1'b0;
            state_d  = S_TURN;
          end else if (idx_q == IW'(DEPTH - 1)) begin
            trdy_d  = 1'b1;
            stop_d  = 1'b0;
            state_d = S_DISC;
          end else begin
            idx_d = idx_nxt;
            if (is_rd_q) ad_out_d = regs[idx_nxt];
          end
        end
      end
      S_DISC: begin
        if (FRAME_) begin
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
          stop_d   = 1'b1;
          ad_oe_d  = 1'b0;
          state_d  = S_TURN;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer and bus output registers; FRAME_ history is tracked even in reset.
  always_ff @(posedge clk) begin
    frame_q <= FRAME_;
    if (reset) begin
      state_q  <= S_IDLE;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      is_rd_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      is_rd_q  <= is_rd_d;
    end
  end

  // Register window storage, written on completed write data phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we) begin
      regs[idx_q] <= wr_dat;
    end
  end

endmodule
